// File: rtl/alsu_pkg.sv
// Shared types and constants for the ALSU command driver: FSM states,
// cmd_data field positions, ALSU opcodes and the default result latency.
package alsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int RESULT_LAT_DEF = 2;

  localparam int A_MSB      = 15;
  localparam int A_LSB      = 13;
  localparam int B_MSB      = 12;
  localparam int B_LSB      = 10;
  localparam int OP_MSB     = 9;
  localparam int OP_LSB     = 7;
  localparam int CIN_BIT    = 6;
  localparam int SERIAL_BIT = 5;
  localparam int DIR_BIT    = 4;
  localparam int RED_A_BIT  = 3;
  localparam int RED_B_BIT  = 2;
  localparam int BYP_A_BIT  = 1;
  localparam int BYP_B_BIT  = 0;

  localparam logic [2:0] OP_AND    = 3'b000;
  localparam logic [2:0] OP_XOR    = 3'b001;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_MUL    = 3'b011;
  localparam logic [2:0] OP_SHIFT  = 3'b100;
  localparam logic [2:0] OP_ROTATE = 3'b101;

endpackage

// File: rtl/alsu_sat_cnt.sv
// 8-bit event counter that sticks at 255 instead of wrapping.
module alsu_sat_cnt (
  input  logic       clk,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/alsu_driver.sv
// Drives one command at a time onto registered ALSU pins, holds it for the
// requested repeat plus the ALSU latency, then offers the captured result.
module alsu_driver
  import alsu_pkg::*;
#(
  parameter int RESULT_LAT = RESULT_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  input  logic [3:0]  cmd_repeat,
  output logic [2:0]  alsu_A,
  output logic [2:0]  alsu_B,
  output logic [2:0]  alsu_opcode,
  output logic        alsu_cin,
  output logic        alsu_serial_in,
  output logic        alsu_direction,
  output logic        alsu_red_op_A,
  output logic        alsu_red_op_B,
  output logic        alsu_byPass_A,
  output logic        alsu_byPass_B,
  input  logic [5:0]  alsu_out,
  input  logic        alsu_valid,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [5:0]  rsp_out,
  output logic        rsp_err,
  output logic [7:0]  cmd_count,
  output logic [7:0]  err_count,
  output logic [1:0]  fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; cmd_ready only in IDLE (and never while rst is high),
  // rsp_valid only in RESP, with rsp_out/rsp_err frozen until taken.

  localparam logic [2:0] LAT_INIT = 3'(RESULT_LAT);

  state_t      state_q;
  logic [15:0] pins_q;
  logic [3:0]  hold_q;
  logic [2:0]  lat_q;
  logic        done;
  logic        err_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pins_q  <= '0;
      hold_q  <= '0;
      lat_q   <= '0;
      rsp_out <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            pins_q  <= cmd_data;
            hold_q  <= cmd_repeat;
            state_q <= DRIVE;
          end
        end
        DRIVE: begin
          if (hold_q == 4'd0) begin
            lat_q   <= LAT_INIT;
            state_q <= WAIT;
          end else begin
            hold_q <= hold_q - 4'd1;
          end
        end
        WAIT: begin
          // Last WAIT edge: the ALSU output has settled for this command.
          if (lat_q == 3'd1) begin
            rsp_out <= alsu_out;
            rsp_err <= ~alsu_valid;
            state_q <= RESP;
          end else begin
            lat_q <= lat_q - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            pins_q  <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RESP);
  assign fsm_state = state_q;

  assign done     = (state_q == RESP) && rsp_ready;
  assign err_done = done && rsp_err;

  assign alsu_A         = pins_q[A_MSB:A_LSB];
  assign alsu_B         = pins_q[B_MSB:B_LSB];
  assign alsu_opcode    = pins_q[OP_MSB:OP_LSB];
  assign alsu_cin       = pins_q[CIN_BIT];
  assign alsu_serial_in = pins_q[SERIAL_BIT];
  assign alsu_direction = pins_q[DIR_BIT];
  assign alsu_red_op_A  = pins_q[RED_A_BIT];
  assign alsu_red_op_B  = pins_q[RED_B_BIT];
  assign alsu_byPass_A  = pins_q[BYP_A_BIT];
  assign alsu_byPass_B  = pins_q[BYP_B_BIT];

  alsu_sat_cnt u_cmd_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (done),
    .count (cmd_count)
  );

  alsu_sat_cnt u_err_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (err_done),
    .count (err_count)
  );

endmodule

// File: tb/tb_alsu_driver.sv
// Bench for alsu_driver with a two-stage registered ALSU model (latency 2)
// on its pins; responses are checked against a queue of expected results.
module tb_alsu_driver;
  import alsu_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_data = '0;
  logic [3:0]  cmd_repeat = '0;
  logic [2:0]  alsu_A, alsu_B, alsu_opcode;
  logic        alsu_cin, alsu_serial_in, alsu_direction;
  logic        alsu_red_op_A, alsu_red_op_B, alsu_byPass_A, alsu_byPass_B;
  logic [5:0]  alsu_out;
  logic        alsu_valid;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [5:0]  rsp_out;
  logic        rsp_err;
  logic [7:0]  cmd_count, err_count;
  logic [1:0]  fsm_state;

  logic [15:0] pins;
  logic [15:0] alsu_in;
  logic [6:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_cmd = 0;
  int          exp_err = 0;

  alsu_driver #(.RESULT_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_repeat(cmd_repeat),
    .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode),
    .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in),
    .alsu_direction(alsu_direction), .alsu_red_op_A(alsu_red_op_A),
    .alsu_red_op_B(alsu_red_op_B), .alsu_byPass_A(alsu_byPass_A),
    .alsu_byPass_B(alsu_byPass_B),
    .alsu_out(alsu_out), .alsu_valid(alsu_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_err(rsp_err),
    .cmd_count(cmd_count), .err_count(err_count),
    .fsm_state(fsm_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  assign pins = {alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in,
                 alsu_direction, alsu_red_op_A, alsu_red_op_B,
                 alsu_byPass_A, alsu_byPass_B};

  // ALSU model: returns {valid, out}; shift/rotate act on the current output.
  function automatic logic [6:0] alsu_f(input logic [15:0] p, input logic [5:0] cur);
    logic [2:0] a, b, op;
    logic [5:0] r;
    a = p[15:13];
    b = p[12:10];
    op = p[9:7];
    r = '0;
    if (op == 3'b110 || op == 3'b111 || ((p[3] || p[2]) && op != OP_AND && op != OP_XOR))
      return 7'd0;
    if (p[1]) return {1'b1, 3'b000, a};
    if (p[0]) return {1'b1, 3'b000, b};
    case (op)
      OP_AND:    r = p[3] ? {5'd0, &a} : p[2] ? {5'd0, &b} : {3'b000, a & b};
      OP_XOR:    r = p[3] ? {5'd0, ^a} : p[2] ? {5'd0, ^b} : {3'b000, a ^ b};
      OP_ADD:    r = 6'(a) + 6'(b) + 6'(p[6]);
      OP_MUL:    r = 6'(a) * 6'(b);
      OP_SHIFT:  r = p[4] ? {cur[4:0], p[5]} : {p[5], cur[5:1]};
      default:   r = p[4] ? {cur[4:0], cur[5]} : {cur[0], cur[5:1]};
    endcase
    return {1'b1, r};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      alsu_in    <= '0;
      alsu_out   <= '0;
      alsu_valid <= 1'b1;
    end else begin
      alsu_in <= pins;
      {alsu_valid, alsu_out} <= alsu_f(alsu_in, alsu_out);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [2:0] a, input logic [2:0] b,
                                     input logic [2:0] op, input logic cin,
                                     input logic sin, input logic dir,
                                     input logic ra, input logic rb,
                                     input logic ba, input logic bb);
    return {a, b, op, cin, sin, dir, ra, rb, ba, bb};
  endfunction

  // Scoreboard monitor: one pop per accepted response.
  initial begin
    logic [6:0] e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got out=%0d err=%0d, expected no response", rsp_out, rsp_err);
        end else begin
          e = exp_q.pop_front();
          check("rsp_out", rsp_out, e[5:0]);
          check("rsp_err", rsp_err, e[6]);
        end
      end
    end
  end

  // Driver: issue one command, track DRIVE length, latency, pin hold and
  // optional response backpressure, then the IDLE cycle and counters.
  task automatic run_cmd(input logic [15:0] data, input logic [3:0] rep,
                         input logic [5:0] eo, input logic ee, input int hold);
    int n;
    int drive_n;
    int bad_pins;
    exp_q.push_back({ee, eo});
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_data = data; cmd_repeat = rep;
    n = 0;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("cmd_ready_wait", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_data = 16'($urandom);
    cmd_repeat = 4'($urandom_range(0, 15));
    n = 0; drive_n = 0; bad_pins = 0;
    while (!rsp_valid && n < 100) begin
      if (fsm_state == 2'(DRIVE)) drive_n++;
      if (pins != data) bad_pins++;
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, 32'(rep) + 1 + LAT);
    check("drive_cycles", drive_n, 32'(rep) + 1);
    check("pins_held", bad_pins, 0);
    for (int i = 0; i < hold; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_out", rsp_out, eo);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_pins", pins, data);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_after_resp", fsm_state, 2'(IDLE));
    check("pins_cleared", pins, 0);
    check("rsp_valid_low", rsp_valid, 0);
    check("cmd_ready_idle", cmd_ready, 1);
    if (exp_cmd < 255) exp_cmd++;
    if (ee && exp_err < 255) exp_err++;
    check("cmd_count", cmd_count, exp_cmd);
    check("err_count", err_count, exp_err);
  endtask

  task automatic run_vec(input int k, input int hold);
    case (k)
      0: run_cmd(mk(3'd2, 3'd3, OP_ADD, 0, 0, 0, 0, 0, 0, 0), 4'd0, 6'd5,  1'b0, hold);
      1: run_cmd(mk(3'd2, 3'd3, OP_MUL, 0, 0, 0, 0, 0, 0, 0), 4'd0, 6'd6,  1'b0, hold);
      2: run_cmd(mk(3'd2, 3'd3, OP_MUL, 0, 0, 0, 1, 0, 0, 0), 4'd0, 6'd0,  1'b1, hold);
      3: run_cmd(mk(3'd7, 3'd5, OP_AND, 0, 0, 0, 0, 0, 0, 0), 4'd0, 6'd5,  1'b0, hold);
      4: run_cmd(mk(3'd6, 3'd5, OP_XOR, 0, 0, 0, 0, 0, 0, 0), 4'd1, 6'd3,  1'b0, hold);
      5: run_cmd(mk(3'd7, 3'd7, OP_ADD, 1, 0, 0, 0, 0, 0, 0), 4'd0, 6'd15, 1'b0, hold);
      6: run_cmd(mk(3'd7, 3'd2, OP_AND, 0, 0, 0, 1, 0, 0, 0), 4'd2, 6'd1,  1'b0, hold);
      7: run_cmd(mk(3'd6, 3'd1, OP_ADD, 0, 0, 0, 0, 0, 1, 0), 4'd0, 6'd6,  1'b0, hold);
      default: run_cmd(mk(3'd1, 3'd1, 3'b110, 0, 0, 0, 0, 0, 0, 0), 4'd0, 6'd0, 1'b1, hold);
    endcase
  endtask

  initial begin
    int seen;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_state", fsm_state, 2'(IDLE));
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_out", rsp_out, 0);
    check("rst_pins", pins, 0);
    check("rst_cmd_count", cmd_count, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_cmd_ready", cmd_ready, 1);

    run_vec(0, 0);
    run_vec(1, 0);
    run_vec(2, 0);
    run_vec(3, 5);
    run_cmd(mk(3'd0, 3'd0, OP_SHIFT, 0, 1, 1, 0, 0, 0, 0), 4'd9, 6'h3F, 1'b0, 0);
    for (int k = 4; k < 9; k++) run_vec(k, 0);

    // Reset on the third DRIVE cycle of a long command.
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_data = mk(3'd5, 3'd2, OP_SHIFT, 0, 1, 1, 0, 0, 0, 0);
    cmd_repeat = 4'd9;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_drive_state", fsm_state, 2'(DRIVE));
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_state", fsm_state, 2'(IDLE));
    check("mid_rst_pins", pins, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    check("mid_rst_cmd_count", cmd_count, 0);
    check("mid_rst_err_count", err_count, 0);
    rst = 1'b0;
    exp_cmd = 0;
    exp_err = 0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    check("no_rsp_after_rst", seen, 0);

    for (int i = 0; i < 260; i++) run_vec(i % 9, 0);
    check("sat_cmd_count", cmd_count, 255);
    check("sat_err_count", err_count, 57);

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
